// File: rtl/soft_error_monitor.sv
// rtl/soft_error_monitor.sv - soft-error event counters with sticky threshold flags (optional rate window: SOFT_ERR_RATE_WINDOW_EN)
module soft_error_monitor #(
    parameter int CNT_W         = 32,
    parameter int WINDOW_CYCLES = 125000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_errors,
    input  logic             cs_mismatch,
    input  logic             unknown_ttc_cmd,
    input  logic             ddr3_overflow,
    input  logic [CNT_W-1:0] thres_data_corrupt,
    input  logic [CNT_W-1:0] thres_unknown_ttc,
    input  logic [CNT_W-1:0] thres_ddr3_overflow,
    output logic [CNT_W-1:0] cs_mismatch_count,
    output logic [CNT_W-1:0] unknown_cmd_count,
    output logic [CNT_W-1:0] ddr3_overflow_count,
    output logic             error_data_corrupt,
    output logic             error_unknown_ttc,
    output logic             error_ddr3_overflow,
    output logic             window_tick
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel order everywhere: 0 = checksum mismatch, 1 = unknown TTC, 2 = DDR3 overflow
    logic [2:0]       ev_in;
    logic [2:0]       ev_d1;
    logic [2:0]       ev;
    logic [CNT_W-1:0] thr   [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       flag_q;
    logic             win_wrap;

    assign ev_in  = {ddr3_overflow, unknown_ttc_cmd, cs_mismatch};
    assign ev     = ev_in & ~ev_d1;
    assign thr[0] = thres_data_corrupt;
    assign thr[1] = thres_unknown_ttc;
    assign thr[2] = thres_ddr3_overflow;

`ifdef SOFT_ERR_RATE_WINDOW_EN
    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    logic [WIN_W-1:0] win_cnt;
    logic             tick_q;

    assign win_wrap    = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign window_tick = tick_q;

    // Free-running window counter; clear_errors restarts the window
    always_ff @(posedge clk) begin
        if (!reset || clear_errors) begin
            win_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (win_wrap) begin
            win_cnt <= '0;
            tick_q  <= 1'b1;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            tick_q  <= 1'b0;
        end
    end
`else
    // Window length only matters in the rate-window build
    logic unused_window;
    assign unused_window = (WINDOW_CYCLES == 0);
    assign win_wrap      = 1'b0;
    assign window_tick   = 1'b0;
`endif

    // Edge-detect history; deliberately untouched by clear_errors so held inputs are not re-counted
    always_ff @(posedge clk) begin
        if (!reset) begin
            ev_d1 <= '0;
        end else begin
            ev_d1 <= ev_in;
        end
    end

    // Saturating event counters; clear beats a coincident event, window wrap restarts at that event
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset || clear_errors) begin
                cnt_q[i] <= '0;
            end else if (win_wrap) begin
                cnt_q[i] <= ev[i] ? CNT_ONE : '0;
            end else if (ev[i] && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Sticky flags compare the registered count; a zero threshold disables setting but never clears
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset || clear_errors) begin
                flag_q[i] <= 1'b0;
            end else if ((thr[i] != '0) && (cnt_q[i] >= thr[i])) begin
                flag_q[i] <= 1'b1;
            end
        end
    end

    assign cs_mismatch_count   = cnt_q[0];
    assign unknown_cmd_count   = cnt_q[1];
    assign ddr3_overflow_count = cnt_q[2];
    assign error_data_corrupt  = flag_q[0];
    assign error_unknown_ttc   = flag_q[1];
    assign error_ddr3_overflow = flag_q[2];

endmodule

// File: tb/tb_soft_error_monitor.sv
// tb/tb_soft_error_monitor.sv - scoreboard testbench for soft_error_monitor
module tb_soft_error_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_errors;
    logic        cs_mismatch, unknown_ttc_cmd, ddr3_overflow;
    logic [31:0] thr_dc, thr_ut, thr_do;
    logic [31:0] cs_cnt, ut_cnt, do_cnt;
    logic        err_dc, err_ut, err_do, tick;

    logic        sat_cs;
    logic [3:0]  sat_cnt_cs, sat_cnt_ut, sat_cnt_do;
    logic        sat_e0, sat_e1, sat_e2, sat_tick;

    always #5 clk = ~clk;

    soft_error_monitor dut (
        .clk(clk), .reset(reset), .clear_errors(clear_errors),
        .cs_mismatch(cs_mismatch), .unknown_ttc_cmd(unknown_ttc_cmd), .ddr3_overflow(ddr3_overflow),
        .thres_data_corrupt(thr_dc), .thres_unknown_ttc(thr_ut), .thres_ddr3_overflow(thr_do),
        .cs_mismatch_count(cs_cnt), .unknown_cmd_count(ut_cnt), .ddr3_overflow_count(do_cnt),
        .error_data_corrupt(err_dc), .error_unknown_ttc(err_ut), .error_ddr3_overflow(err_do),
        .window_tick(tick)
    );

    // Narrow instance so saturation at all-ones is reachable in a few cycles
    soft_error_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .clear_errors(1'b0),
        .cs_mismatch(sat_cs), .unknown_ttc_cmd(1'b0), .ddr3_overflow(1'b0),
        .thres_data_corrupt(4'd0), .thres_unknown_ttc(4'd0), .thres_ddr3_overflow(4'd0),
        .cs_mismatch_count(sat_cnt_cs), .unknown_cmd_count(sat_cnt_ut), .ddr3_overflow_count(sat_cnt_do),
        .error_data_corrupt(sat_e0), .error_unknown_ttc(sat_e1), .error_ddr3_overflow(sat_e2),
        .window_tick(sat_tick)
    );

`ifdef SOFT_ERR_RATE_WINDOW_EN
    logic        w_clear, w_cs;
    logic [31:0] w_cs_cnt, w_ut_cnt, w_do_cnt;
    logic        w_e0, w_e1, w_e2, w_tick;

    soft_error_monitor #(.WINDOW_CYCLES(16)) u_win (
        .clk(clk), .reset(reset), .clear_errors(w_clear),
        .cs_mismatch(w_cs), .unknown_ttc_cmd(1'b0), .ddr3_overflow(1'b0),
        .thres_data_corrupt(32'd3), .thres_unknown_ttc(32'd0), .thres_ddr3_overflow(32'd0),
        .cs_mismatch_count(w_cs_cnt), .unknown_cmd_count(w_ut_cnt), .ddr3_overflow_count(w_do_cnt),
        .error_data_corrupt(w_e0), .error_unknown_ttc(w_e1), .error_ddr3_overflow(w_e2),
        .window_tick(w_tick)
    );
`endif

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_val(input int sel);
        case (sel)
            0: return cs_cnt;
            1: return ut_cnt;
            2: return do_cnt;
            3: return {31'd0, err_dc};
            4: return {31'd0, err_ut};
            5: return {31'd0, err_do};
            6: return {31'd0, tick};
            7: return {28'd0, sat_cnt_cs};
`ifdef SOFT_ERR_RATE_WINDOW_EN
            8: return w_cs_cnt;
            9: return {31'd0, w_e0};
            10: return {31'd0, w_tick};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input int delay, input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.at   = cyc + delay;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every scheduled expectation on the falling edge of its cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                logic [31:0] act;
                act = get_val(sb[i].sel);
                checks++;
                if (act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b0; clear_errors = 1'b0;
        cs_mismatch = 1'b0; unknown_ttc_cmd = 1'b0; ddr3_overflow = 1'b0;
        thr_dc = 32'd0; thr_ut = 32'd0; thr_do = 32'd0;
        sat_cs = 1'b0;
`ifdef SOFT_ERR_RATE_WINDOW_EN
        w_clear = 1'b0; w_cs = 1'b0;
`endif
        step(); step(); step();
        expect_at(0, "rst_cs_cnt", 0, 32'd0);
        expect_at(0, "rst_ut_cnt", 1, 32'd0);
        expect_at(0, "rst_do_cnt", 2, 32'd0);
        expect_at(0, "rst_err_dc", 3, 32'd0);
        expect_at(0, "rst_err_ut", 4, 32'd0);
        expect_at(0, "rst_err_do", 5, 32'd0);
        expect_at(0, "rst_tick",   6, 32'd0);

        reset  = 1'b1;
        thr_dc = 32'd5;
        step();

        // Five checksum pulses against threshold 5
        for (int p = 1; p <= 5; p++) begin
            cs_mismatch = 1'b1;
            expect_at(1, "cs_count", 0, 32'(p));
            expect_at(1, "err_dc_pre", 3, 32'd0);
            if (p == 5) begin
                expect_at(2, "err_dc_set", 3, 32'd1);
                expect_at(6, "err_dc_sticky", 3, 32'd1);
            end
            step();
            cs_mismatch = 1'b0;
            step();
        end
        checks++;
        if (cs_cnt !== 32'd5 || err_dc !== 1'b1) begin
            errors++;
            $display("FAIL direct_cs_five: cnt %0h err %0b", cs_cnt, err_dc);
        end

        // Held-high unknown TTC command counts once; zero threshold never flags
        unknown_ttc_cmd = 1'b1;
        expect_at(1,   "ut_count_first", 1, 32'd1);
        expect_at(100, "ut_count_held",  1, 32'd1);
        expect_at(100, "err_ut_disabled", 4, 32'd0);
        repeat (100) step();
        unknown_ttc_cmd = 1'b0;
        step();
        checks++;
        if (ut_cnt !== 32'd1 || err_ut !== 1'b0) begin
            errors++;
            $display("FAIL direct_ut_held: cnt %0h err %0b", ut_cnt, err_ut);
        end

        ddr3_overflow = 1'b1;
        expect_at(1, "do_count_pre", 2, 32'd1);
        step();
        ddr3_overflow = 1'b0;
        step();

        // clear_errors coincident with a checksum edge
        clear_errors = 1'b1;
        cs_mismatch  = 1'b1;
        expect_at(1, "clr_cs_cnt", 0, 32'd0);
        expect_at(1, "clr_ut_cnt", 1, 32'd0);
        expect_at(1, "clr_do_cnt", 2, 32'd0);
        expect_at(1, "clr_err_dc", 3, 32'd0);
        expect_at(1, "clr_err_ut", 4, 32'd0);
        expect_at(1, "clr_err_do", 5, 32'd0);
        step();
        clear_errors  = 1'b0;
        ddr3_overflow = 1'b1;
        expect_at(1, "cs_not_recounted", 0, 32'd0);
        expect_at(1, "do_after_clear",   2, 32'd1);
        step();
        ddr3_overflow = 1'b0;
        cs_mismatch   = 1'b0;
        step();

        // Bring DDR3 count to 10, then program threshold below it
        repeat (9) begin
            ddr3_overflow = 1'b1;
            step();
            ddr3_overflow = 1'b0;
            step();
        end
        expect_at(0, "do_count_10", 2, 32'd10);
        expect_at(0, "err_do_idle", 5, 32'd0);
        thr_do = 32'd8;
        expect_at(1, "err_do_set", 5, 32'd1);
        step();
        thr_do = 32'd0;
        expect_at(1, "err_do_thr0", 5, 32'd1);
        expect_at(3, "err_do_thr0_hold", 5, 32'd1);
        step(); step(); step();

        // Simultaneous events on all three channels
        cs_mismatch = 1'b1; unknown_ttc_cmd = 1'b1; ddr3_overflow = 1'b1;
        expect_at(1, "sim_cs", 0, 32'd1);
        expect_at(1, "sim_ut", 1, 32'd1);
        expect_at(1, "sim_do", 2, 32'd11);
        expect_at(1, "sim_err_dc", 3, 32'd0);
        step();
        cs_mismatch = 1'b0; unknown_ttc_cmd = 1'b0; ddr3_overflow = 1'b0;
        expect_at(0, "tick_idle", 6, 32'd0);
        step();
        checks++;
        if (do_cnt !== 32'd11) begin
            errors++;
            $display("FAIL direct_do_sim: cnt %0h", do_cnt);
        end

        // Saturation on the 4-bit instance: 14, 15, then held at 15
        for (int p = 1; p <= 17; p++) begin
            sat_cs = 1'b1;
            expect_at(1, "sat_count", 7, (p > 15) ? 32'd15 : 32'(p));
            step();
            sat_cs = 1'b0;
            step();
        end
        checks++;
        if (sat_cnt_cs !== 4'd15) begin
            errors++;
            $display("FAIL direct_sat_hold: cnt %0h", sat_cnt_cs);
        end

`ifdef SOFT_ERR_RATE_WINDOW_EN
        // Window of 16: restart via clear, 3 events, event on the wrap edge
        w_clear = 1'b1;
        expect_at(7,  "win_cnt_3",      8,  32'd3);
        expect_at(8,  "win_err_set",    9,  32'd1);
        expect_at(16, "win_cnt_pre",    8,  32'd3);
        expect_at(16, "win_tick_pre",   10, 32'd0);
        expect_at(17, "win_tick",       10, 32'd1);
        expect_at(17, "win_cnt_wrap",   8,  32'd1);
        expect_at(18, "win_tick_post",  10, 32'd0);
        expect_at(20, "win_err_sticky", 9,  32'd1);
        step();
        w_clear = 1'b0;
        step();
        repeat (3) begin
            w_cs = 1'b1;
            step();
            w_cs = 1'b0;
            step();
        end
        repeat (9) step();
        w_cs = 1'b1;
        step();
        w_cs = 1'b0;
        repeat (6) step();
`endif

        repeat (5) step();
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never compared, got none expected %0h", sb[i].name, sb[i].val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soft_error_monitor.md
Name: soft_error_monitor

Overview:
- Upstream feeder of the Rider status register block.
- Detects soft-error events: checksum mismatch, unknown TTC broadcast command, DDR3 overflow.
- Keeps saturating 32-bit counts of each event and compares them to IPbus-programmed thresholds.
- Drives sticky hard-error flags; counts and flags go straight to the status registers.

Parameters:
- CNT_W, 32, counter/threshold width.
- WINDOW_CYCLES, 125000000, rate-window length in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  user-interface clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- clear_errors  input  1  single-cycle pulse; zeroes counts and sticky flags.
- cs_mismatch  input  1  level/pulse from checksum checker; counted on rising edge.
- unknown_ttc_cmd  input  1  level/pulse from TTC decoder; counted on rising edge.
- ddr3_overflow  input  1  level/pulse from DDR3 controller; counted on rising edge.
- thres_data_corrupt  input  CNT_W  threshold for cs_mismatch; 0 = disabled.
- thres_unknown_ttc  input  CNT_W  threshold for unknown_ttc_cmd; 0 = disabled.
- thres_ddr3_overflow  input  CNT_W  threshold for ddr3_overflow; 0 = disabled.
- cs_mismatch_count  output  CNT_W  mismatch count.
- unknown_cmd_count  output  CNT_W  unknown TTC command count.
- ddr3_overflow_count  output  CNT_W  DDR3 overflow count.
- error_data_corrupt  output  1  sticky; mismatch threshold reached.
- error_unknown_ttc  output  1  sticky; unknown-command threshold reached.
- error_ddr3_overflow  output  1  sticky; overflow threshold reached.
- window_tick  output  1  one-cycle pulse at window rollover; tied 0 when the feature is absent.

Behaviour:
- Reset (reset==0 at a clk edge):
  - all counts 0, all error flags 0, window_tick 0;
  - edge-detect history registers 0, so an input already high when reset releases counts once.
- Edge detect: event = in & ~in_d1, with in_d1 registered every cycle. A held-high input counts exactly once.
- Counters (three identical instances):
  - Event at edge N: count increments, visible after edge N+1 (latency 1).
  - Saturate at all-ones; no wrap.
- Error flags:
  - Set when threshold!=0 and count>=threshold, comparing the registered count. Flag is visible one cycle after the count reaches the threshold (two cycles after the event).
  - Sticky; cleared only by reset or clear_errors.
  - A threshold written at or below the current count sets the flag on the next cycle.
  - A threshold set to 0 never sets the flag and does not clear a flag already set.
- clear_errors:
  - Zeroes all counts and flags at the next edge.
  - An event on the same cycle is discarded; clear wins, count=0.
  - An event on the following cycle counts normally.
  - Edge-detect history is not cleared, so a held-high input is not re-counted.
- The three channels are independent; simultaneous events on all three each increment their own counter in the same cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SOFT_ERR_RATE_WINDOW_EN.
- Defined:
  - A free-running window counter counts 0..WINDOW_CYCLES-1, then wraps.
  - At wrap: window_tick pulses for one cycle and all three counts are zeroed on that edge.
  - An event coincident with the wrap edge is counted as 1 in the new window.
  - Error flags are not cleared at wrap, so thresholds become per-window rate limits.
  - clear_errors also restarts the window counter at 0.
- Not defined:
  - No window counter; window_tick tied 0; counts accumulate until reset or clear_errors.
  - WINDOW_CYCLES unused.

Test Plan:
- Reset, then 5 cs_mismatch pulses with thres_data_corrupt=5 -> count 1..5; error_data_corrupt rises exactly one cycle after count==5 and stays 1.
- unknown_ttc_cmd held high 100 cycles with thres_unknown_ttc=0 -> unknown_cmd_count==1; error_unknown_ttc stays 0.
- Force ddr3_overflow_count to 0xFFFFFFFE, apply 3 edges -> count holds 0xFFFFFFFF, no wrap to 0.
- clear_errors on the same cycle as a cs_mismatch edge, with flags set -> all counts 0 and all flags 0 next cycle; that event is not counted.
- Count=10, then thres_ddr3_overflow written 0->8 -> error_ddr3_overflow=1 one cycle later; then writing threshold back to 0 keeps the flag at 1.
- With SOFT_ERR_RATE_WINDOW_EN, WINDOW_CYCLES=16:
  - 3 events in window 1 -> window_tick at cycle 16 and counts zeroed.
  - An event on the tick edge -> count=1.
  - Flags set in window 1 are still 1 in window 2.
